mips_muldiv: RTL

Iterative multiply/divide unit for the execute stage, beside `mips_alu`. It takes the same two register operands (rs, rt) for MULT/MULTU/DIV/DIVU. It computes the result over 34 cycles and holds it in the architectural HI/LO registers. The decode/stall logic holds off MFHI/MFLO while `md_busy` is high, and MTHI/MTLO write HI/LO directly through this block.

---
 rtl/mips_muldiv.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_muldiv.sv
// Iterative 34-cycle multiply/divide unit holding the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with sign fixup at the end.
module mips_muldiv #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] md_in1,
    input  logic [31:0] md_in2,
    input  logic        md_flush,
    input  logic        md_wr_hi,
    input  logic        md_wr_lo,
    input  logic [31:0] md_wdata,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo,
    output logic        md_busy,
    output logic        md_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    state_t      state_r, state_s;
    logic [1:0]  op_r;
    logic [31:0] in1_r, in2_r, dsr_r;
    logic [63:0] acc_r;
    logic [4:0]  cnt_r;
    logic        neg_res_r, neg_rem_r;
    logic [31:0] hi_r, lo_r;
    logic        done_r;

    logic        signed_op_s;
    logic [31:0] abs_a_s, abs_b_s;
    logic [32:0] mul_sum_s, trial_s;
    logic [63:0] acc_iter_s, prod_s;
    logic [31:0] quo_s, rmd_s, fix_hi_s, fix_lo_s;

    // Magnitude of a value when it is treated as signed and negative.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a flush in any busy state drops straight back to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (md_start) begin
                    state_s = S_PREP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PREP: begin
                if (md_flush) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_ITER;
                end
            end
            S_ITER: begin
                if (md_flush) begin
                    state_s = S_IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_ITER;
                end
            end
            S_FIX: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // One iteration step: shift-add for multiply, 33-bit trial subtract for divide.
    always_comb begin
        signed_op_s = ~op_r[0];
        abs_a_s     = mag32(in1_r, signed_op_s);
        abs_b_s     = mag32(in2_r, signed_op_s);
        mul_sum_s   = {1'b0, acc_r[63:32]} + {1'b0, dsr_r};
        trial_s     = acc_r[63:31] - {1'b0, dsr_r};
        if (op_r[1]) begin
            if (!trial_s[32]) begin
                acc_iter_s = {trial_s[31:0], acc_r[30:0], 1'b1};
            end else begin
                acc_iter_s = {acc_r[62:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                acc_iter_s = {mul_sum_s, acc_r[31:1]};
            end else begin
                acc_iter_s = {1'b0, acc_r[63:1]};
            end
        end
    end

    // Sign fixup and final HI/LO selection; divide-by-zero overrides the iterated result.
    always_comb begin
        prod_s = neg_res_r ? (64'd0 - acc_r) : acc_r;
        quo_s  = neg_res_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
        rmd_s  = neg_rem_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
        if (!op_r[1]) begin
            fix_hi_s = prod_s[63:32];
            fix_lo_s = prod_s[31:0];
        end else if (in2_r == 32'd0) begin
            fix_hi_s = in1_r;
            fix_lo_s = 32'hFFFF_FFFF;
        end else begin
            fix_hi_s = rmd_s;
            fix_lo_s = quo_s;
        end
    end

    // Datapath and HI/LO registers; MTHI/MTLO only land in IDLE when no start is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r      <= 2'd0;
            in1_r     <= 32'd0;
            in2_r     <= 32'd0;
            dsr_r     <= 32'd0;
            acc_r     <= 64'd0;
            cnt_r     <= 5'd0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state_r == S_FIX) && !md_flush;
            case (state_r)
                S_IDLE: begin
                    if (md_start) begin
                        op_r  <= md_op;
                        in1_r <= md_in1;
                        in2_r <= md_in2;
                    end else begin
                        if (md_wr_hi) begin
                            hi_r <= md_wdata;
                        end
                        if (md_wr_lo) begin
                            lo_r <= md_wdata;
                        end
                    end
                end
                S_PREP: begin
                    // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                    acc_r     <= {32'd0, (op_r[1] ? abs_a_s : abs_b_s)};
                    dsr_r     <= op_r[1] ? abs_b_s : abs_a_s;
                    neg_res_r <= signed_op_s & (in1_r[31] ^ in2_r[31]);
                    neg_rem_r <= signed_op_s & in1_r[31];
                    cnt_r     <= 5'd0;
                end
                S_ITER: begin
                    acc_r <= acc_iter_s;
                    cnt_r <= cnt_r + 5'd1;
                end
                S_FIX: begin
                    if (!md_flush) begin
                        hi_r <= fix_hi_s;
                        lo_r <= fix_lo_s;
                    end
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

    assign md_busy = (state_r != S_IDLE);
    assign md_hi   = hi_r;
    assign md_lo   = lo_r;
    assign md_done = done_r;

endmodule
